// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the supported VGA modes, plus helpers that
//   derive axis totals and counter widths from the porch/sync/active widths.
//   No ports; imported by vga_timing_gen and any other display block.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic        sync_pol;
    } axis_timing_t;

    // 640x480 @ 60 Hz, 25 MHz pixel clock, negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_SYNC_POL = 0;

    // 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;
    localparam int SVGA800_SYNC_POL = 1;

    localparam axis_timing_t VGA640_H = '{16'd640, 16'd16, 16'd96, 16'd48, 1'b0};
    localparam axis_timing_t VGA640_V = '{16'd480, 16'd10, 16'd2, 16'd33, 1'b0};
    localparam axis_timing_t SVGA800_H = '{16'd800, 16'd56, 16'd120, 16'd64, 1'b1};
    localparam axis_timing_t SVGA800_V = '{16'd600, 16'd37, 16'd6, 16'd23, 1'b1};

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Width of a counter spanning 0..total-1; never narrower than one bit
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// pix_ce_gen
//   Integer clock-enable divider: one pix_ce per CLK_DIV enabled clocks.
//   Ports:
//     clk    - system clock
//     rst    - synchronous active-high reset (divider returns to 0)
//     en     - run enable; low holds the divider and masks pix_ce
//     pix_ce - combinational, en && divider at its last count
module pix_ce_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_ce
);

    localparam int DIV_W = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_ce_gen: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div;

    // With CLK_DIV=1 the divider stays parked at 0 == DIV_LAST, so pix_ce = en
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign pix_ce = en && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator.
//   Ports:
//     clk         - system clock (single domain; pixel rate via pix_ce)
//     rst         - synchronous active-high reset
//     en          - run enable; low freezes raster and strobes
//     pix_ce      - pixel clock-enable from the divider
//     hsync/vsync - registered syncs, polarity from H_/V_SYNC_POL
//     de          - registered display enable
//     col/row     - current raster position
//     line_start  - one clk pulse when col becomes 0
//     frame_start - one clk pulse when (col,row) becomes (0,0)
//     frame_count - completed-frame counter, wraps
//   Reset parks the raster at (H_TOTAL-1, V_TOTAL-1) in back porch so the
//   first pixel after release is (0,0) with a frame_start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_W    = 16,
    localparam int H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int COL_W     = cnt_width(H_TOTAL),
    localparam int ROW_W     = cnt_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COL_W-1:0]   col,
    output logic [ROW_W-1:0]   row,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: horizontal porch/sync widths must be >= 1");
    end
    if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: vertical porch/sync widths must be >= 1");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_SYNC_POL != 0 && H_SYNC_POL != 1) begin : g_bad_hpol
        $error("vga_timing_gen: H_SYNC_POL must be 0 or 1");
    end
    if (V_SYNC_POL != 0 && V_SYNC_POL != 1) begin : g_bad_vpol
        $error("vga_timing_gen: V_SYNC_POL must be 0 or 1");
    end

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_TOTAL - 1);
    localparam logic [COL_W-1:0] COL_DE    = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_DE    = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] HS_FIRST  = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] HS_LAST   = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [ROW_W-1:0] VS_FIRST  = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] VS_LAST   = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON     = 1'(H_SYNC_POL);
    localparam logic             VS_ON     = 1'(V_SYNC_POL);

    pix_ce_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_ce_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pix_ce (pix_ce)
    );

    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             de_nxt;

    always_comb begin
        col_nxt = col + 1'b1;
        row_nxt = row;
        if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
        end
    end

    // Decode from the next position so syncs/de land with col/row on the same edge
    always_comb begin
        hsync_nxt = (col_nxt >= HS_FIRST && col_nxt <= HS_LAST) ? HS_ON : ~HS_ON;
        vsync_nxt = (row_nxt >= VS_FIRST && row_nxt <= VS_LAST) ? VS_ON : ~VS_ON;
        de_nxt    = (col_nxt < COL_DE) && (row_nxt < ROW_DE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= COL_LAST;
            row         <= ROW_LAST;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                col         <= col_nxt;
                row         <= row_nxt;
                hsync       <= hsync_nxt;
                vsync       <= vsync_nxt;
                de          <= de_nxt;
                line_start  <= (col_nxt == '0);
                frame_start <= (col_nxt == '0) && (row_nxt == '0);
                if ((col_nxt == '0) && (row_nxt == '0)) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Small raster (15x8 totals, CLK_DIV=3, positive hsync / negative vsync,
//   FRAME_W=2) so many frames, frame_count wraps and mid-frame resets fit in
//   a short run. Expected position is derived from the number of pixel
//   advances since the last reset, as a linear index into the frame.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HPOL = 1, VPOL = 0;
    localparam int DIV = 3;
    localparam int FW = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HT * VT;
    localparam int CW = $clog2(HT);
    localparam int RW = $clog2(VT);
    localparam int NCYC = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          pix_ce, hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW-1:0] frame_count;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_SYNC_POL (HPOL), .V_SYNC_POL (VPOL),
        .CLK_DIV (DIV), .FRAME_W (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pix_ce      (pix_ce),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .col         (col),
        .row         (row),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: enabled clocks since reset, and whether the last edge was a pixel advance
    int  en_cnt = 0;
    bit  last_adv = 1'b0;
    bit  valid = 1'b0;
    int  hold_low = 0;
    int  frames_seen = 0;

    initial begin
        int t, lin, c, r, fc;
        bit exp_hs, exp_vs, exp_de;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (valid)
                check_val("pix_ce", 32'(pix_ce), 32'(en && (en_cnt % DIV == DIV - 1)));

            @(posedge clk);
            if (rst) begin
                en_cnt   = 0;
                last_adv = 1'b0;
                valid    = 1'b1;
            end else if (en) begin
                last_adv = (en_cnt % DIV == DIV - 1);
                en_cnt++;
            end else begin
                last_adv = 1'b0;
            end
            #1;

            if (valid) begin
                t   = en_cnt / DIV;
                lin = (NPIX - 1 + t) % NPIX;
                c   = lin % HT;
                r   = lin / HT;
                fc  = ((t + NPIX - 1) / NPIX) % (1 << FW);
                exp_hs = (c >= HA + HF && c <= HA + HF + HS - 1) ? 1'(HPOL) : ~1'(HPOL);
                exp_vs = (r >= VA + VF && r <= VA + VF + VS - 1) ? 1'(VPOL) : ~1'(VPOL);
                exp_de = (c < HA) && (r < VA);
                check_val("col", 32'(col), 32'(c));
                check_val("row", 32'(row), 32'(r));
                check_val("hsync", 32'(hsync), 32'(exp_hs));
                check_val("vsync", 32'(vsync), 32'(exp_vs));
                check_val("de", 32'(de), 32'(exp_de));
                check_val("line_start", 32'(line_start), 32'(last_adv && c == 0));
                check_val("frame_start", 32'(frame_start), 32'(last_adv && c == 0 && r == 0));
                check_val("frame_count", 32'(frame_count), 32'(fc));
                if (last_adv && c == 0 && r == 0) frames_seen++;
            end

            rst = (cyc < 2) || ($urandom_range(0, 4999) == 0);
            if (hold_low > 0) begin
                hold_low--;
                en = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                hold_low = 10;
                en = 1'b0;
            end else begin
                en = ($urandom_range(0, 7) != 0);
            end
            #1;
        end

        // The run must have spanned enough frames to wrap the 2-bit counter
        check_val("frames_seen_enough", 32'(frames_seen > 8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
